fft_mul_rnd_pipe: RTL and testbench
===================================

Name: fft_mul_rnd_pipe

Overview:
- Parametrised pipelined multiplier for FFT twiddle and scaling paths; successor to the fixed 18x15 signed-by-unsigned DSP48 multiplier.
- Adds per-operand signedness, configurable pipeline depth and a valid strobe.
- Adds a post-product shift with selectable rounding, saturation to the output width, and per-sample plus sticky overflow flags.
- Maps to one DSP48 plus fabric for round/saturate.

Parameters:
- A_WIDTH, 18, width of din0.
- B_WIDTH, 15, width of din1.
- A_SIGNED, 1, 1 = din0 two's complement, 0 = unsigned.
- B_SIGNED, 0, 1 = din1 two's complement, 0 = unsigned (zero-extended).
- SHIFT, 15, arithmetic right shift applied to the full product; range 0..A_WIDTH+B_WIDTH-1.
- ROUND_MODE, 1, 0 = truncate (floor), 1 = round half up, 2 = convergent (half to even).
- DOUT_WIDTH, 16, output width; result is saturated to this width.
- NUM_STAGE, 4, total latency in ce-qualified cycles; legal range 3..8.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- ce, input, 1, clock enable; when 0 every register holds.
- din_valid, input, 1, marks din0/din1 as a valid sample.
- din0, input, A_WIDTH, operand A.
- din1, input, B_WIDTH, operand B.
- dout_valid, output, 1, dout is a valid result.
- dout, output, DOUT_WIDTH, rounded and saturated product, signed.
- ovf, output, 1, saturation occurred on the sample currently on dout.
- ovf_sticky, output, 1, latched OR of ovf since the last clear.
- clr_ovf, input, 1, synchronous clear of ovf_sticky (ce-qualified).

Behaviour:
- Reset (reset=0, asynchronous): all pipeline data registers, valid bits, dout, dout_valid, ovf and ovf_sticky go to 0 immediately. Release is synchronous to clk; the first capture happens on the first ce=1 edge after release.
- Widths:
  - Each operand is extended by one bit per its SIGNED parameter, giving a signed A_WIDTH+1 by B_WIDTH+1 multiply.
  - Full product P_WIDTH = A_WIDTH+B_WIDTH+2 (signed), no loss.
- Pipeline, with every stage advancing only when ce=1:
  - S1: register din0, din1, din_valid.
  - S2: register the full product.
  - S3..S(NUM_STAGE-1): pure delay registers. Zero of these when NUM_STAGE=3.
  - Final stage: registered shift, round, saturate.
  - Latency from a ce=1 capture edge to dout is NUM_STAGE ce=1 edges.
  - The valid bit travels alongside the data. Invalid samples still propagate data, but dout_valid=0 for them.
- Rounding on P >> SHIFT (arithmetic):
  - Mode 0: floor.
  - Mode 1: add 2^(SHIFT-1), then floor.
  - Mode 2: as mode 1, except when the discarded bits equal exactly half and the kept LSB is 0, no increment.
  - When SHIFT=0, all modes pass the value through unchanged.
  - Rounding addition is done one bit wider than P_WIDTH, so it never wraps.
- Saturation:
  - A rounded value above 2^(DOUT_WIDTH-1)-1 clamps to that maximum; a value below -2^(DOUT_WIDTH-1) clamps to that minimum.
  - ovf=1 for that sample; otherwise ovf=0.
  - ovf is gated by valid: forced 0 when dout_valid=0.
- ovf_sticky, on a ce=1 edge:
  - Set if the final stage produces ovf=1.
  - Else cleared if clr_ovf=1.
  - Set has priority over a simultaneous clear.
- ce=0: outputs, flags and the sticky bit hold their values; din_valid and clr_ovf are ignored.
- Reset asserted mid-stream: in-flight samples are discarded and no dout_valid is produced for them.

Test Plan:
- Config A=18s, B=15u, SHIFT=15, DOUT=16, mode 1, NUM_STAGE=4, ce=1. Drive din0=1000, din1=16384 with valid -> exactly 4 edges later dout=500, dout_valid=1, ovf=0; every other cycle has dout_valid=0.
- Same config, rounding sweep with din1=16384:
  - din0=3 -> mode0 1, mode1 2, mode2 2.
  - din0=5 -> mode0 2, mode1 3, mode2 2.
  - din0=-3 -> mode0 -2, mode1 -1, mode2 -2.
- Saturation:
  - din0=131071, din1=32767 -> dout=32767, ovf=1, ovf_sticky=1.
  - Then din0=-131072, din1=32767 -> dout=-32768, ovf=1.
  - Then din0=2, din1=16384 -> dout=1, ovf=0, ovf_sticky stays 1.
- Sticky priority: clr_ovf=1 on the same edge an overflow sample exits -> ovf_sticky=1. clr_ovf=1 on a clean edge -> ovf_sticky=0.
- Stall: back-to-back valid samples 1,2,3 (din1=32768>>1), with ce toggled 1,0,0,1,1,0,1... -> results appear in order after 4 ce=1 edges each; outputs held while ce=0; no duplicates or drops.
- Reset mid-stream: 3 valid samples in flight, then reset=0 for 1 cycle (asynchronous, between edges) -> dout, dout_valid, ovf, ovf_sticky go to 0 immediately. After release, none of the 3 samples emerge; a new sample emerges after 4 edges.
- Signedness matrix: A_SIGNED=0, B_SIGNED=1, SHIFT=0, DOUT=34. din0=18'h3FFFF, din1=15'h7FFF -> dout=-262143. Swapped to A_SIGNED=1, B_SIGNED=0 -> dout=-32767.

Source files
------------

// File: rtl/fft_mul_rnd_pipe.sv
`default_nettype none
// ============================================================================
// Module : fft_mul_rnd_pipe
// Pipelined multiplier with per-operand signedness, shift, rounding, saturation.
// Rev    : 1.0  initial release
// ============================================================================
module fft_mul_rnd_pipe #(
   parameter int A_WIDTH    = 18,
   parameter int B_WIDTH    = 15,
   parameter int A_SIGNED   = 1,
   parameter int B_SIGNED   = 0,
   parameter int SHIFT      = 15,
   parameter int ROUND_MODE = 1,
   parameter int DOUT_WIDTH = 16,
   parameter int NUM_STAGE  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ce,
   input  logic                         din_valid,
   input  logic [A_WIDTH-1:0]           din0,
   input  logic [B_WIDTH-1:0]           din1,
   input  logic                         clr_ovf,
   output logic                         dout_valid,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         ovf,
   output logic                         ovf_sticky
);

   localparam int c_PW = A_WIDTH + B_WIDTH + 2;
   localparam int c_EW = c_PW + 1;
   localparam int c_RW = ((c_EW > DOUT_WIDTH) ? c_EW : DOUT_WIDTH) + 1;
   localparam int c_ND = NUM_STAGE - 3;
   localparam logic signed [c_RW-1:0] c_MAX =
      {{(c_RW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [c_RW-1:0] c_MIN =
      {{(c_RW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   logic [A_WIDTH-1:0]           r_a;
   logic [B_WIDTH-1:0]           r_b;
   logic                         r_v1;
   logic signed [c_PW-1:0]       r_p;
   logic                         r_v2;
   logic                         w_a_msb;
   logic                         w_b_msb;
   logic signed [c_PW-1:0]       w_ax;
   logic signed [c_PW-1:0]       w_bx;
   logic signed [c_PW-1:0]       w_pd;
   logic                         w_vd;
   logic signed [c_EW-1:0]       w_pe;
   logic signed [c_EW-1:0]       w_shr;
   logic signed [c_RW-1:0]       w_rx;
   logic signed [DOUT_WIDTH-1:0] w_dout;
   logic                         w_sat;

   // Operands widened to the full product width so the multiply cannot truncate
   assign w_a_msb = (A_SIGNED != 0) ? r_a[A_WIDTH-1] : 1'b0;
   assign w_b_msb = (B_SIGNED != 0) ? r_b[B_WIDTH-1] : 1'b0;
   assign w_ax    = {{(c_PW-A_WIDTH){w_a_msb}}, r_a};
   assign w_bx    = {{(c_PW-B_WIDTH){w_b_msb}}, r_b};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a  <= '0;
         r_b  <= '0;
         r_v1 <= 1'b0;
         r_p  <= '0;
         r_v2 <= 1'b0;
      end else if (ce) begin
         r_a  <= din0;
         r_b  <= din1;
         r_v1 <= din_valid;
         r_p  <= w_ax * w_bx;
         r_v2 <= r_v1;
      end
   end

   generate
      if (c_ND == 0) begin : g_no_dly
         assign w_pd = r_p;
         assign w_vd = r_v2;
      end else begin : g_dly
         logic signed [c_PW-1:0] r_dp [c_ND];
         logic [c_ND-1:0]        r_dv;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < c_ND; i++) r_dp[i] <= '0;
               r_dv <= '0;
            end else if (ce) begin
               r_dp[0] <= r_p;
               r_dv[0] <= r_v2;
               for (int i = 1; i < c_ND; i++) begin
                  r_dp[i] <= r_dp[i-1];
                  r_dv[i] <= r_dv[i-1];
               end
            end
         end

         assign w_pd = r_dp[c_ND-1];
         assign w_vd = r_dv[c_ND-1];
      end
   endgenerate

   // One guard bit keeps the rounding increment from wrapping
   assign w_pe = {w_pd[c_PW-1], w_pd};

   generate
      if (SHIFT == 0) begin : g_no_shift
         assign w_shr = w_pe;
      end else begin : g_shift
         localparam logic [c_EW-1:0] c_HALF = {{(c_EW-1){1'b0}}, 1'b1} << (SHIFT - 1);
         logic                   w_tie;
         logic                   w_inc;
         logic signed [c_EW-1:0] w_sum;

         // Exact half with an even kept LSB: convergent rounding leaves it alone
         assign w_tie = (w_pe[SHIFT-1:0] == c_HALF[SHIFT-1:0]) && !w_pe[SHIFT];

         always_comb begin
            w_inc = 1'b0;
            case (ROUND_MODE)
               1:       w_inc = 1'b1;
               2:       w_inc = !w_tie;
               default: w_inc = 1'b0;
            endcase
         end

         assign w_sum = w_pe + (w_inc ? c_HALF : '0);
         assign w_shr = w_sum >>> SHIFT;
      end
   endgenerate

   assign w_rx = {{(c_RW-c_EW){w_shr[c_EW-1]}}, w_shr};

   always_comb begin
      w_dout = w_rx[DOUT_WIDTH-1:0];
      w_sat  = 1'b0;
      if (w_rx > c_MAX) begin
         w_dout = c_MAX[DOUT_WIDTH-1:0];
         w_sat  = 1'b1;
      end else if (w_rx < c_MIN) begin
         w_dout = c_MIN[DOUT_WIDTH-1:0];
         w_sat  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         ovf        <= 1'b0;
         ovf_sticky <= 1'b0;
      end else if (ce) begin
         dout       <= w_dout;
         dout_valid <= w_vd;
         ovf        <= w_sat & w_vd;
         if (w_sat && w_vd) begin
            ovf_sticky <= 1'b1;
         end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_mul_rnd_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_mul_rnd_pipe
// Self-checking bench: vector table + scoreboard, plus stall/reset/sticky cases.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fft_mul_rnd_pipe;

   typedef struct {
      int a;
      int b;
      int e0;
      int e1;
      int e2;
      bit o0;
      bit o1;
      bit o2;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ce = 1'b1;
   logic        din_valid = 1'b0;
   logic [17:0] din0 = '0;
   logic [14:0] din1 = '0;
   logic        clr_ovf = 1'b0;

   logic               dv1, dv0, dv2, dvu, dvs;
   logic signed [15:0] do1, do0, do2;
   logic signed [33:0] dou, dos;
   logic               ov1, ov0, ov2, ovu, ovs;
   logic               st1, st0, st2, stu, sts;

   int   checks = 0;
   int   errors = 0;
   vec_t q[$];
   vec_t tbl[13];
   bit   last_ce = 1'b0;
   logic signed [15:0] prev_do = '0;
   logic prev_dv = 1'b0;
   logic prev_st = 1'b0;

   always #5 clk = ~clk;

   fft_mul_rnd_pipe #(.ROUND_MODE(1)) dut (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .clr_ovf(clr_ovf), .dout_valid(dv1), .dout(do1), .ovf(ov1), .ovf_sticky(st1));
   fft_mul_rnd_pipe #(.ROUND_MODE(0)) dut_m0 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .clr_ovf(clr_ovf), .dout_valid(dv0), .dout(do0), .ovf(ov0), .ovf_sticky(st0));
   fft_mul_rnd_pipe #(.ROUND_MODE(2)) dut_m2 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .clr_ovf(clr_ovf), .dout_valid(dv2), .dout(do2), .ovf(ov2), .ovf_sticky(st2));
   fft_mul_rnd_pipe #(.A_SIGNED(0), .B_SIGNED(1), .SHIFT(0), .DOUT_WIDTH(34)) dut_us (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .clr_ovf(clr_ovf), .dout_valid(dvu), .dout(dou), .ovf(ovu), .ovf_sticky(stu));
   fft_mul_rnd_pipe #(.A_SIGNED(1), .B_SIGNED(0), .SHIFT(0), .DOUT_WIDTH(34)) dut_su (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .clr_ovf(clr_ovf), .dout_valid(dvs), .dout(dos), .ovf(ovs), .ovf_sticky(sts));

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int a, input int b, input bit v);
      din0      = a[17:0];
      din1      = b[14:0];
      din_valid = v;
   endtask

   // Called right after a valid sample is driven on a negedge
   task automatic lat_check(input string name);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) din_valid = 1'b0;
         chk(name, longint'(dv1), longint'(k == 4));
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 60 && q.size() != 0; n++) @(negedge clk);
      chk("drain_queue_empty", longint'(q.size()), 0);
   endtask

   always @(posedge clk) last_ce <= ce;

   // Scoreboard: a new result appears only after a ce=1 edge
   always @(negedge clk) begin
      if (reset) begin
         if (last_ce && dv1) begin
            if (q.size() == 0) begin
               chk("unexpected_dout_valid", longint'(do1), -99999);
            end else begin
               vec_t e;
               e = q.pop_front();
               chk("dout_mode1", longint'(do1), e.e1);
               chk("ovf_mode1", longint'(ov1), longint'(e.o1));
               chk("valid_mode0", longint'(dv0), 1);
               chk("dout_mode0", longint'(do0), e.e0);
               chk("ovf_mode0", longint'(ov0), longint'(e.o0));
               chk("valid_mode2", longint'(dv2), 1);
               chk("dout_mode2", longint'(do2), e.e2);
               chk("ovf_mode2", longint'(ov2), longint'(e.o2));
            end
         end
         if (!last_ce) begin
            chk("hold_dout", longint'(do1), longint'(prev_do));
            chk("hold_valid", longint'(dv1), longint'(prev_dv));
            chk("hold_sticky", longint'(st1), longint'(prev_st));
         end
         if (!dv1) chk("ovf_gated", longint'(ov1), 0);
      end
      prev_do <= do1;
      prev_dv <= dv1;
      prev_st <= st1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pat[7];
      int idx;
      pat = '{1, 0, 0, 1, 1, 0, 1};
      tbl[0]  = '{1000, 16384, 500, 500, 500, 0, 0, 0};
      tbl[1]  = '{3, 16384, 1, 2, 2, 0, 0, 0};
      tbl[2]  = '{5, 16384, 2, 3, 2, 0, 0, 0};
      tbl[3]  = '{-3, 16384, -2, -1, -2, 0, 0, 0};
      tbl[4]  = '{1, 16384, 0, 1, 0, 0, 0, 0};
      tbl[5]  = '{-1, 16384, -1, 0, 0, 0, 0, 0};
      tbl[6]  = '{131071, 32767, 32767, 32767, 32767, 1, 1, 1};
      tbl[7]  = '{-131072, 32767, -32768, -32768, -32768, 1, 1, 1};
      tbl[8]  = '{2, 16384, 1, 1, 1, 0, 0, 0};
      tbl[9]  = '{65535, 16384, 32767, 32767, 32767, 0, 1, 1};
      tbl[10] = '{-65536, 16384, -32768, -32768, -32768, 0, 0, 0};
      tbl[11] = '{-65537, 16384, -32768, -32768, -32768, 1, 0, 0};
      tbl[12] = '{0, 32767, 0, 0, 0, 0, 0, 0};

      #3;
      chk("rst_dout", longint'(do1), 0);
      chk("rst_valid", longint'(dv1), 0);
      chk("rst_ovf", longint'(ov1), 0);
      chk("rst_sticky", longint'(st1), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single-sample latency
      drive(1000, 16384, 1);
      q.push_back(tbl[0]);
      lat_check("latency_first");
      drain();

      // Vector table, invalid junk samples interleaved
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(tbl[i].a, tbl[i].b, 1);
         q.push_back(tbl[i]);
         if (i % 2 == 1) begin
            @(negedge clk);
            drive(131071, 32767, 0);
         end
      end
      @(negedge clk);
      drive(0, 0, 0);
      drain();
      chk("sticky_after_table", longint'(st1), 1);

      // Sticky clear, invalid overflow data, set-over-clear priority
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      chk("sticky_clear", longint'(st1), 0);
      drive(131071, 32767, 0);
      repeat (6) @(negedge clk);
      chk("sticky_invalid_ovf", longint'(st1), 0);
      drive(131071, 32767, 1);
      q.push_back(tbl[6]);
      @(negedge clk); din_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      chk("sticky_priority", longint'(st1), 1);
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      chk("sticky_clean_clear", longint'(st1), 0);
      drain();

      // Stall with ce pattern
      idx = 0;
      for (int c = 0; c < 28; c++) begin
         @(negedge clk);
         ce = pat[c % 7];
         if (ce) begin
            if (idx < 3) begin
               drive(idx + 1, 16384, 1);
               q.push_back('{idx + 1, 16384, (idx + 1) / 2, (idx + 2) / 2, (idx == 0) ? 0 : idx, 0, 0, 0});
               idx++;
            end else begin
               din_valid = 1'b0;
            end
         end
      end
      @(negedge clk);
      ce = 1'b1;
      din_valid = 1'b0;
      drain();

      // Signedness variants fed the same operands
      @(negedge clk);
      drive(32'h3FFFF, 32'h7FFF, 1);
      q.push_back('{-1, 32767, -1, -1, -1, 0, 0, 0});
      @(negedge clk); din_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("us_valid", longint'(dvu), 1);
      chk("us_dout", longint'(dou), -262143);
      chk("su_valid", longint'(dvs), 1);
      chk("su_dout", longint'(dos), -32767);
      chk("us_su_ovf", longint'({ovu, ovs, stu, sts}), 0);
      drain();

      // Reset with samples in flight
      @(negedge clk);
      drive(131071, 32767, 1);
      q.push_back(tbl[6]);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1000, 16384, 1);
      end
      @(negedge clk);
      din_valid = 1'b0;
      chk("sticky_pre_reset", longint'(st1), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_dout", longint'(do1), 0);
      chk("async_rst_valid", longint'(dv1), 0);
      chk("async_rst_ovf", longint'(ov1), 0);
      chk("async_rst_sticky", longint'(st1), 0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
      drive(1000, 16384, 1);
      q.push_back(tbl[0]);
      lat_check("latency_after_reset");
      drain();
      chk("sticky_final", longint'({st1, st0, st2}), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
